mc_ctl_fsm: RTL and testbench
=============================

Name: mc_ctl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath.
- Decodes the instruction opcode, steps the datapath through fetch, decode, execute, memory and writeback, and drives the 2-bit ALUop consumed by aluCtl.
- Handshakes with instruction/data memory (mem_req/mem_ready), bounds each memory wait with a timeout, and reports instruction retirement.

Parameters:
- MAX_WAIT, 16, max cycles spent in one memory state without mem_ready before the ERR state is entered.
- WAIT_W, 5, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous and active-low, sampled on the clk rising edge.
- opcode  in  6  instr[31:26] from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  PC load qualified by ALU zero.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- ALUop  out  2  00 = add, 01 = sub, 10 = funct field (to aluCtl).
- instr_done  out  1  one-cycle retirement pulse.
- err  out  1  memory timeout; sticky until reset.
- state  out  4  current state code (debug).

Behaviour:
- Moore outputs are decoded from the state register. Exceptions: IRWrite, PCWrite (in FETCH) and MemWrite are additionally ANDed with mem_ready.
- Every output not listed for a state is 0.
- Reset: on a clk edge with rst_n=0, state goes to FETCH(0) and wait_cnt to 0. Applies from any state, including mid-access and ERR/TRAP.
- After reset, outputs equal the FETCH decode.
- FETCH(0): mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSrc=00. On mem_ready, IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Other opcodes -> see Optional Feature.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD(3): mem_req=1, IorD=1. On mem_ready -> MEMWB.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
- MEMWR(5): mem_req=1, IorD=1, MemWrite=mem_ready. On mem_ready, instr_done=1 and go to FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUop=10. Go to ALUWB.
- ALUWB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Go to FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUop=01, Branch=1, PCSrc=01, instr_done=1. Go to FETCH.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUop=00. Go to ADDIWB(10).
- ADDIWB(10): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Go to FETCH.
- JUMP(11): PCWrite=1, PCSrc=10, instr_done=1. Go to FETCH.
- ERR(14): err=1, all strobes 0, mem_req=0. Held until reset.
- Opcode is sampled each cycle from the IR. The IR is stable from DECODE onward.
- Latency with mem_ready tied high:
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
- Wait counter (memory states FETCH, MEMRD, MEMWR):
  - wait_cnt clears on entry to a memory state.
  - Increments each cycle the state holds with mem_ready=0.
  - If mem_ready=0 and wait_cnt==MAX_WAIT-1, next state is ERR. ERR is therefore reached after exactly MAX_WAIT unready cycles.
  - mem_ready=1 on that final cycle wins: the access completes normally.
- mem_ready asserted in a non-memory state is ignored.

Optional Feature:
- Macro: MC_CTL_ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to TRAP(15). TRAP drives err=1 and all strobes 0, and is held until reset. No instr_done is issued.
- Undefined: an unrecognised opcode is a NOP. DECODE pulses instr_done=1 and returns to FETCH; err stays 0. State 15 is unreachable.

Test Plan:
- Reset: rst_n=0 for 2 edges, mem_ready=0 -> state=0, mem_req=1, ALUSrcB=01, all strobes 0, err=0.
- R-type, opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0; ALUop=10 in state 6; RegWrite=1, RegDst=1 and instr_done=1 only in state 7.
- lw, opcode=100011, mem_ready low for 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0; MemtoReg=1 in state 4; 8 cycles to retirement.
- sw then beq, mem_ready=1:
  - sw: MemWrite=1 for exactly one cycle in state 5.
  - beq: Branch=1, ALUop=01, PCSrc=01 in state 8.
  - j: PCWrite=1, PCSrc=10 in state 11.
- Timeout, MAX_WAIT=16, mem_ready=0 in FETCH:
  - After 16 cycles, state=14 and err=1; err stays 1 for 20 further cycles.
  - rst_n=0 for one edge -> state=0, err=0.
  - Separate run: mem_ready=1 on the 16th wait cycle -> DECODE, no error.
- Illegal opcode 111111:
  - With MC_CTL_ILLEGAL_TRAP_EN: state=15, err=1, no instr_done.
  - Without it: instr_done pulses in state 1, then state=0.

Source files
------------

// File: rtl/mc_ctl_fsm_if.sv
// ============================================================================
// Module   : mc_ctl_fsm_if
// Purpose  : Control/handshake bundle between the multi-cycle sequencer and
//            the datapath/memory. master = sequencer, slave = datapath side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_ctl_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] PCSrc;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic       instr_done;
  logic       err;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite, Branch, PCSrc, MemWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUop,
           instr_done, err, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, IorD, IRWrite, PCWrite, Branch, PCSrc, MemWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUop,
           instr_done, err, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctl_fsm.sv
// ============================================================================
// Module   : mc_ctl_fsm
// Purpose  : Multi-cycle MIPS-subset control sequencer. Steps the datapath
//            through fetch/decode/execute/memory/writeback, bounds each
//            memory wait with a timeout and pulses instr_done on retirement.
// Options  : MC_CTL_ILLEGAL_TRAP_EN - unknown opcodes trap (state 15, err=1)
//            instead of retiring as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctl_fsm #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERR    = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  // Moore control word; *_rdy bits are still qualified by mem_ready on output.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irw_rdy;
    logic       pcw;
    logic       pcw_rdy;
    logic       branch;
    logic [1:0] pcsrc;
    logic       mw_rdy;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
    logic       done_rdy;
    logic       err;
  } ctl_t;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.irw_rdy = 1'b1; c.pcw_rdy = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: begin c.alu_src_b = 2'b11; end
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.iord = 1'b1; c.mw_rdy = 1'b1; c.done_rdy = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
      S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.branch = 1'b1; c.pcsrc = 2'b01; c.done = 1'b1; end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB: begin c.reg_write = 1'b1; c.done = 1'b1; end
      S_JUMP:   begin c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; end
      S_ERR:    begin c.err = 1'b1; end
      S_TRAP:   begin c.err = 1'b1; end
      default:  begin c = '0; end
    endcase
    return c;
  endfunction

  state_t            r_state;
  state_t            w_next;
  ctl_t              r_ctl;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_is_mem;
  logic              w_timeout;
  logic              w_nop;

  assign w_is_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = !bus.mem_ready && (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));

`ifdef MC_CTL_ILLEGAL_TRAP_EN
  assign w_nop = 1'b0;
`else
  // An unrecognised opcode retires straight out of DECODE as a NOP.
  assign w_nop = (r_state == S_DECODE) &&
                 !(bus.opcode inside {C_OP_RTYPE, C_OP_J, C_OP_BEQ, C_OP_ADDI, C_OP_LW, C_OP_SW});
`endif

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (bus.mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_ERR;
      S_DECODE: begin
        case (bus.opcode)
          C_OP_LW, C_OP_SW: w_next = S_MEMADR;
          C_OP_RTYPE:       w_next = S_EXEC;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_ADDI:        w_next = S_ADDIEX;
          C_OP_J:           w_next = S_JUMP;
          default: begin
`ifdef MC_CTL_ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: w_next = (bus.opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB; else if (w_timeout) w_next = S_ERR;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH; else if (w_timeout) w_next = S_ERR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ERR:    w_next = S_ERR;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // State, wait counter and the control word for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_ctl      <= decode(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctl   <= decode(w_next);
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_is_mem && !bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign bus.mem_req    = r_ctl.mem_req;
  assign bus.IorD       = r_ctl.iord;
  assign bus.IRWrite    = r_ctl.irw_rdy & bus.mem_ready;
  assign bus.PCWrite    = r_ctl.pcw | (r_ctl.pcw_rdy & bus.mem_ready);
  assign bus.Branch     = r_ctl.branch;
  assign bus.PCSrc      = r_ctl.pcsrc;
  assign bus.MemWrite   = r_ctl.mw_rdy & bus.mem_ready;
  assign bus.RegWrite   = r_ctl.reg_write;
  assign bus.RegDst     = r_ctl.reg_dst;
  assign bus.MemtoReg   = r_ctl.mem_to_reg;
  assign bus.ALUSrcA    = r_ctl.alu_src_a;
  assign bus.ALUSrcB    = r_ctl.alu_src_b;
  assign bus.ALUop      = r_ctl.alu_op;
  assign bus.instr_done = r_ctl.done | (r_ctl.done_rdy & bus.mem_ready) | w_nop;
  assign bus.err        = r_ctl.err;
  assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctl_fsm.sv
// ============================================================================
// Module   : tb_mc_ctl_fsm
// Purpose  : Self-checking bench for mc_ctl_fsm: directed instruction
//            vectors, timeout/reset corner sequences and a randomized run
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctl_fsm;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctl_fsm_if bus();

  mc_ctl_fsm #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_out();
    return {bus.mem_req, bus.IorD, bus.IRWrite, bus.PCWrite, bus.Branch, bus.PCSrc,
            bus.MemWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUop, bus.instr_done, bus.err};
  endfunction

  function automatic logic known_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100011, 6'b101011};
  endfunction

  // Output table written straight from the per-state output list.
  function automatic logic [17:0] exp_out(input int st, input logic mr, input logic [5:0] op);
    logic req, iord, irw, pcw, br, mw, rw, rd, m2r, asa, done, e;
    logic [1:0] pcs, asb, aop;
    {req, iord, irw, pcw, br, mw, rw, rd, m2r, asa, done, e} = '0;
    {pcs, asb, aop} = '0;
    case (st)
      0:  begin req = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin
            asb = 2'b11;
`ifndef MC_CTL_ILLEGAL_TRAP_EN
            done = !known_op(op);
`endif
          end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin req = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin req = 1; iord = 1; mw = mr; done = mr; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; done = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin pcw = 1; pcs = 2'b10; done = 1; end
      14, 15: begin e = 1; end
      default: ;
    endcase
    return {req, iord, irw, pcw, br, pcs, mw, rw, rd, m2r, asa, asb, aop, done, e};
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: opcode, optional stall in one state, expected trace.
  typedef struct {
    string      name;
    logic [5:0] op;
    int         stall_st;
    int         stall;
    int         len;
    int         done_at;
    int         seq[10];
  } vec_t;

  vec_t vt[8];

  // Reference model state for the random run: pending state trace of the
  // current instruction, cycles waited in the present memory access, error flag.
  int         q[$];
  int         m_wait;
  bit         m_err;
  logic [5:0] cur_op;

  task automatic load_path(input logic [5:0] op);
    q.delete();
    q.push_back(1);
    case (op)
      6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      6'b101011: begin q.push_back(2); q.push_back(5); end
      6'b000000: begin q.push_back(6); q.push_back(7); end
      6'b000100: q.push_back(8);
      6'b001000: begin q.push_back(9); q.push_back(10); end
      6'b000010: q.push_back(11);
      default: begin
`ifdef MC_CTL_ILLEGAL_TRAP_EN
        q.push_back(15);
`endif
      end
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [8];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b001100};
    return ops[$urandom_range(0, 7)];
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int stall_cnt, done_idx, n_done, cur;
    logic mr, rst;
    logic [31:0] rnd;

    vt[0] = '{name:"rtype", op:6'b000000, stall_st:-1, stall:0, len:5,  done_at:3, seq:'{0,1,6,7,0,0,0,0,0,0}};
    vt[1] = '{name:"lw_stall", op:6'b100011, stall_st:3, stall:3, len:9, done_at:7, seq:'{0,1,2,3,3,3,3,4,0,0}};
    vt[2] = '{name:"sw",    op:6'b101011, stall_st:-1, stall:0, len:5,  done_at:3, seq:'{0,1,2,5,0,0,0,0,0,0}};
    vt[3] = '{name:"beq",   op:6'b000100, stall_st:-1, stall:0, len:4,  done_at:2, seq:'{0,1,8,0,0,0,0,0,0,0}};
    vt[4] = '{name:"addi",  op:6'b001000, stall_st:-1, stall:0, len:5,  done_at:3, seq:'{0,1,9,10,0,0,0,0,0,0}};
    vt[5] = '{name:"j",     op:6'b000010, stall_st:-1, stall:0, len:4,  done_at:2, seq:'{0,1,11,0,0,0,0,0,0,0}};
    vt[6] = '{name:"fetch_stall", op:6'b000000, stall_st:0, stall:5, len:10, done_at:8, seq:'{0,0,0,0,0,0,1,6,7,0}};
`ifdef MC_CTL_ILLEGAL_TRAP_EN
    vt[7] = '{name:"illegal", op:6'b111111, stall_st:-1, stall:0, len:5, done_at:-1, seq:'{15,15,15,15,15,15,15,15,15,15}};
    vt[7].seq[0] = 0; vt[7].seq[1] = 1;
`else
    vt[7] = '{name:"illegal", op:6'b111111, stall_st:-1, stall:0, len:3, done_at:1, seq:'{0,1,0,0,0,0,0,0,0,0}};
`endif

    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;

    // Reset state
    do_reset(2);
    @(negedge clk);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_outs", 32'(dut_out()), 32'(exp_out(0, 1'b0, bus.opcode)));
    chk("reset_err", 32'(bus.err), 32'd0);

    // Directed instruction vectors
    for (int v = 0; v < 8; v++) begin
      do_reset(1);
      bus.opcode = vt[v].op;
      stall_cnt = 0;
      done_idx = -1;
      n_done = 0;
      for (int i = 0; i < vt[v].len; i++) begin
        mr = 1'b1;
        if (vt[v].seq[i] == vt[v].stall_st && stall_cnt < vt[v].stall) begin
          mr = 1'b0;
          stall_cnt++;
        end
        bus.mem_ready = mr;
        @(negedge clk);
        chk({vt[v].name, "_state"}, 32'(bus.state), 32'(vt[v].seq[i]));
        chk({vt[v].name, "_outs"}, 32'(dut_out()), 32'(exp_out(vt[v].seq[i], mr, vt[v].op)));
        if (bus.instr_done) begin
          n_done++;
          if (done_idx < 0) done_idx = i;
        end
        step();
      end
      chk({vt[v].name, "_done_cycle"}, 32'(done_idx), 32'(vt[v].done_at));
      chk({vt[v].name, "_done_count"}, 32'(n_done), (vt[v].done_at >= 0) ? 32'd1 : 32'd0);
    end

    // FETCH timeout: 16 unready cycles reach ERR, which is sticky until reset
    do_reset(1);
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (i == MAX_WAIT - 1) chk("to_last_wait_state", 32'(bus.state), 32'd0);
      step();
    end
    @(negedge clk);
    chk("to_err_state", 32'(bus.state), 32'd14);
    chk("to_err_flag", 32'(bus.err), 32'd1);
    step();
    for (int i = 0; i < 20; i++) begin
      rnd = $urandom;
      bus.mem_ready = rnd[0];
      @(negedge clk);
      chk("to_err_sticky", 32'(bus.err), 32'd1);
      chk("to_err_outs", 32'(dut_out()), 32'(exp_out(14, bus.mem_ready, bus.opcode)));
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("to_reset_state", 32'(bus.state), 32'd0);
    chk("to_reset_err", 32'(bus.err), 32'd0);
    step();

    // mem_ready on the final (16th) wait cycle completes the fetch
    do_reset(1);
    bus.opcode = 6'b000000;
    for (int i = 0; i < MAX_WAIT; i++) begin
      bus.mem_ready = (i == MAX_WAIT - 1);
      step();
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_state", 32'(bus.state), 32'd1);
    chk("late_ready_err", 32'(bus.err), 32'd0);

    // MEMRD timeout; mem_ready in DECODE/MEMADR is ignored
    do_reset(1);
    bus.opcode = 6'b100011;
    bus.mem_ready = 1'b1; step();          // FETCH completes
    bus.mem_ready = 1'b0; step();          // DECODE
    bus.mem_ready = 1'b1;                  // MEMADR
    @(negedge clk);
    chk("memrd_to_adr", 32'(bus.state), 32'd2);
    step();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("memrd_to_entry", 32'(bus.state), 32'd3);
    repeat (MAX_WAIT) step();
    @(negedge clk);
    chk("memrd_to_err", 32'(bus.state), 32'd14);

    // Reset in the middle of a stalled load
    do_reset(1);
    bus.opcode = 6'b100011;
    bus.mem_ready = 1'b1; step();
    bus.mem_ready = 1'b0; step(); step(); step(); step();
    @(negedge clk);
    chk("midreset_pre", 32'(bus.state), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_post", 32'(bus.state), 32'd0);

    // Randomized run against the instruction-level model
    do_reset(1);
    q.delete(); q.push_back(0);
    m_wait = 0; m_err = 0; cur_op = 6'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cur = m_err ? 14 : q[0];
      mr  = ($urandom_range(0, 99) < 65);
      rst = ($urandom_range(0, 299) == 0);
      rst_n = !rst;
      bus.mem_ready = mr;
      if (cur == 0) begin
        rnd = $urandom;
        bus.opcode = rnd[5:0];
      end else begin
        bus.opcode = cur_op;
      end
      @(negedge clk);
      chk("rnd_state", 32'(bus.state), 32'(cur));
      chk("rnd_outs", 32'(dut_out()), 32'(exp_out(cur, mr, bus.opcode)));
      if (rst) begin
        q.delete(); q.push_back(0);
        m_wait = 0; m_err = 0;
      end else if (!m_err && cur != 15) begin
        if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin
          if (m_wait == MAX_WAIT - 1) m_err = 1;
          else m_wait++;
        end else begin
          void'(q.pop_front());
          m_wait = 0;
          if (cur == 0) begin
            cur_op = pick_op();
            load_path(cur_op);
          end
          if (q.size() == 0) q.push_back(0);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
